// File: rtl/mesm6_mem_pkg.sv
// Shared widths and controller state encoding for the MESM-6 memory responder.
package mesm6_mem_pkg;

    localparam int unsigned WORD_BITS = 48;
    localparam int unsigned ADDR_BITS = 15;

    typedef enum logic [2:0] {
        IDLE,
        D_ACC,
        D_CAP,
        I_ACC,
        I_CAP,
        RESP
    } memctl_state_t;

endpackage

// File: rtl/mesm6_memctl.sv
// Serves the MESM-6 instruction and data buses from one single-port synchronous RAM,
// data access first, and completes both buses together in a single response cycle.
module mesm6_memctl
    import mesm6_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ibus_fetch,
    input  logic [ADDR_BITS-1:0] ibus_addr,
    output logic [WORD_BITS-1:0] ibus_input,
    output logic                 ibus_done,
    input  logic                 dbus_read,
    input  logic                 dbus_write,
    input  logic [ADDR_BITS-1:0] dbus_addr,
    input  logic [WORD_BITS-1:0] dbus_output,
    output logic [WORD_BITS-1:0] dbus_input,
    output logic                 dbus_done,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [WORD_BITS-1:0] ram_wdata,
    input  logic [WORD_BITS-1:0] ram_rdata
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    memctl_state_t        state, state_next;
    logic                 pend_d, pend_i, d_wr;
    logic [ADDR_BITS-1:0] i_addr;
    logic [3:0]           wait_cnt;
    logic                 d_req;
    logic                 acc_last;

    assign d_req    = dbus_read | dbus_write;
    assign acc_last = (wait_cnt == 4'd0);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (d_req)           state_next = D_ACC;
                else if (ibus_fetch) state_next = I_ACC;
                else                 state_next = IDLE;
            end
            D_ACC: begin
                if (acc_last) begin
                    if (!d_wr)       state_next = D_CAP;
                    else if (pend_i) state_next = I_ACC;
                    else             state_next = RESP;
                end
            end
            D_CAP:   state_next = pend_i ? I_ACC : RESP;
            I_ACC:   state_next = acc_last ? I_CAP : I_ACC;
            I_CAP:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ram_en    = (state == D_ACC) || (state == I_ACC);
    assign ram_we    = (state == D_ACC) && d_wr;
    assign ibus_done = (state == RESP) && pend_i;
    assign dbus_done = (state == RESP) && pend_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pend_d     <= 1'b0;
            pend_i     <= 1'b0;
            d_wr       <= 1'b0;
            i_addr     <= '0;
            wait_cnt   <= 4'd0;
            ibus_input <= '0;
            dbus_input <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            state <= state_next;

            // Counter restarts on every entry into an ACC state, including D_ACC -> I_ACC.
            if ((state_next == D_ACC || state_next == I_ACC) && state_next != state) begin
                wait_cnt <= WAIT_INIT;
            end else if (!acc_last) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            case (state)
                IDLE: begin
                    pend_d <= d_req;
                    d_wr   <= dbus_write;
                    pend_i <= ibus_fetch;
                    i_addr <= ibus_addr;
                    if (d_req) begin
                        ram_addr  <= dbus_addr;
                        ram_wdata <= dbus_output;
                    end else if (ibus_fetch) begin
                        ram_addr <= ibus_addr;
                    end
                end
                D_ACC: begin
                    if (state_next == I_ACC) ram_addr <= i_addr;
                end
                D_CAP: begin
                    dbus_input <= ram_rdata;
                    if (state_next == I_ACC) ram_addr <= i_addr;
                end
                I_CAP: begin
                    ibus_input <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_memctl.sv
// Self-checking bench: three controllers (0, 2 and 3 wait states) each with its own RAM,
// directed cases followed by random transactions checked against a latency/memory model.
module tb_mesm6_memctl;
    import mesm6_mem_pkg::*;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst      [NI];
    logic        fetch    [NI];
    logic [14:0] iaddr    [NI];
    logic        rd       [NI];
    logic        wr       [NI];
    logic [14:0] daddr    [NI];
    logic [47:0] dout     [NI];
    logic [47:0] ibus_in  [NI];
    logic [47:0] dbus_in  [NI];
    logic        idone    [NI];
    logic        ddone    [NI];
    logic        ren      [NI];
    logic        rwe      [NI];
    logic [14:0] raddr    [NI];
    logic [47:0] rwdata   [NI];
    logic        pre_en   [NI];
    logic [14:0] pre_addr [NI];
    logic [47:0] pre_data [NI];

    int checks = 0;
    int failures = 0;

    logic [47:0] ref_mem [int];
    logic [47:0] exp_d [NI];
    logic [47:0] exp_i [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        logic [47:0] rdata;
        logic [47:0] mem [0:32767];

        mesm6_memctl #(.WAIT_STATES(g == 0 ? 0 : g + 1)) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .ibus_fetch (fetch[g]),
            .ibus_addr  (iaddr[g]),
            .ibus_input (ibus_in[g]),
            .ibus_done  (idone[g]),
            .dbus_read  (rd[g]),
            .dbus_write (wr[g]),
            .dbus_addr  (daddr[g]),
            .dbus_output(dout[g]),
            .dbus_input (dbus_in[g]),
            .dbus_done  (ddone[g]),
            .ram_en     (ren[g]),
            .ram_we     (rwe[g]),
            .ram_addr   (raddr[g]),
            .ram_wdata  (rwdata[g]),
            .ram_rdata  (rdata)
        );

        // Behavioural 32Kx48 synchronous RAM with a side port for bench preloading.
        always @(posedge clk) begin
            if (pre_en[g]) begin
                mem[pre_addr[g]] <= pre_data[g];
            end else if (ren[g]) begin
                if (rwe[g]) mem[raddr[g]] <= rwdata[g];
                else        rdata <= mem[raddr[g]];
            end
        end
    end

    function automatic int wof(int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    function automatic int key(int i, logic [14:0] a);
        return i * 32768 + int'(a);
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int i, input logic [14:0] a, input logic [47:0] v);
        pre_en[i]   = 1'b1;
        pre_addr[i] = a;
        pre_data[i] = v;
        @(posedge clk);
        #1;
        pre_en[i] = 1'b0;
        ref_mem[key(i, a)] = v;
    endtask

    task automatic ensure(input int i, input logic [14:0] a);
        if (!ref_mem.exists(key(i, a))) preload(i, a, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    endtask

    task automatic idle_inputs(input int i);
        fetch[i] = 1'b0;
        rd[i]    = 1'b0;
        wr[i]    = 1'b0;
    endtask

    // One transaction; expects to be called at posedge+#1 and returns aligned the same way.
    task automatic txn(input string tag, input int i, input bit r, input bit w, input bit f,
                       input logic [14:0] da, input logic [14:0] ia, input logic [47:0] wd);
        int          w_ = wof(i);
        bit          dreq = r | w;
        int          exp_lat, exp_en;
        int          cyc = 0;
        int          en_cnt = 0;
        bit          got = 1'b0;
        logic [14:0] first_a = '0;
        logic [14:0] last_a = '0;
        logic        o_id = 1'b0;
        logic        o_dd = 1'b0;
        logic [47:0] o_di = '0;
        logic [47:0] o_ii = '0;

        if (r && !w) ensure(i, da);
        if (f) ensure(i, ia);

        // Each access costs its RAM cycles plus a capture cycle for reads, then one response.
        exp_lat = 1 + (dreq ? ((w ? 1 : 2) + w_) : 0) + (f ? 2 + w_ : 0);
        exp_en  = (dreq ? 1 + w_ : 0) + (f ? 1 + w_ : 0);
        if (dreq && !w) exp_d[i] = ref_mem[key(i, da)];
        if (w) ref_mem[key(i, da)] = wd;
        if (f) exp_i[i] = ref_mem[key(i, ia)];

        rd[i] = r; wr[i] = w; daddr[i] = da; dout[i] = wd; fetch[i] = f; iaddr[i] = ia;
        @(posedge clk);
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (ren[i]) begin
                if (en_cnt == 0) first_a = raddr[i];
                last_a = raddr[i];
                en_cnt++;
            end
            if (idone[i] || ddone[i]) begin
                got  = 1'b1;
                o_id = idone[i];
                o_dd = ddone[i];
                o_di = dbus_in[i];
                o_ii = ibus_in[i];
            end
        end
        idle_inputs(i);

        chk({tag, " latency"}, 48'(cyc), 48'(exp_lat));
        chk({tag, " ibus_done"}, 48'(o_id), 48'(f));
        chk({tag, " dbus_done"}, 48'(o_dd), 48'(dreq));
        chk({tag, " dbus_input"}, o_di, exp_d[i]);
        chk({tag, " ibus_input"}, o_ii, exp_i[i]);
        chk({tag, " ram_en cycles"}, 48'(en_cnt), 48'(exp_en));
        chk({tag, " first ram_addr"}, 48'(first_a), 48'(dreq ? da : ia));
        chk({tag, " last ram_addr"}, 48'(last_a), 48'(f ? ia : da));
        @(negedge clk);
        chk({tag, " done one cycle"}, 48'(idone[i] | ddone[i]), 48'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, en, extra, cyc;
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            idle_inputs(i);
            iaddr[i] = '0; daddr[i] = '0; dout[i] = '0;
            pre_en[i] = 1'b0; pre_addr[i] = '0; pre_data[i] = '0;
            exp_d[i] = '0; exp_i[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset ibus_input", ibus_in[i], 48'd0);
            chk("reset dbus_input", dbus_in[i], 48'd0);
            chk("reset dones", 48'({idone[i], ddone[i]}), 48'd0);
            chk("reset ram_en/we", 48'({ren[i], rwe[i]}), 48'd0);
            chk("reset ram_addr", 48'(raddr[i]), 48'd0);
            chk("reset ram_wdata", rwdata[i], 48'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;

        preload(0, 15'o00100, 48'h1234_5678_9ABC);
        txn("w0 read", 0, 1, 0, 0, 15'o00100, 15'd0, 48'd0);
        chk("w0 read value", exp_d[0], 48'h1234_5678_9ABC);
        txn("w0 write", 0, 0, 1, 0, 15'o00007, 15'd0, 48'hFFFF_0000_0001);
        txn("w0 readback", 0, 1, 0, 0, 15'o00007, 15'd0, 48'd0);
        preload(1, 15'o77777, 48'h0A0B_0C0D_0E0F);
        txn("w2 fetch", 1, 0, 0, 1, 15'd0, 15'o77777, 48'd0);
        preload(0, 15'o00010, 48'h1111_2222_3333);
        preload(0, 15'o00020, 48'h4444_5555_6666);
        txn("w0 read+fetch", 0, 1, 0, 1, 15'o00010, 15'o00020, 48'd0);

        // Fetch held high across RESP; address advanced as each word completes.
        for (int a = 1; a <= 4; a++) preload(0, 15'(a), 48'hABC0_0000_0000 + 48'(a * 7));
        n = 0; en = 0; cyc = 0; extra = 0;
        fetch[0] = 1'b1;
        iaddr[0] = 15'd1;
        while (n < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ren[0]) en++;
            if (idone[0]) begin
                chk("held fetch data", ibus_in[0], 48'hABC0_0000_0000 + 48'((n + 1) * 7));
                n++;
                if (n < 4) iaddr[0] = 15'(n + 1);
                else fetch[0] = 1'b0;
            end
        end
        fetch[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ren[0]) en++;
            if (idone[0] || ddone[0]) extra++;
        end
        chk("held fetch done count", 48'(n + extra), 48'd4);
        chk("held fetch ram_en cycles", 48'(en), 48'd4);
        exp_i[0] = 48'hABC0_0000_0000 + 48'd28;
        @(posedge clk);
        #1;

        // Reset during the data access of a W=3 read.
        ensure(2, 15'o01234);
        rd[2] = 1'b1;
        daddr[2] = 15'o01234;
        @(posedge clk);
        @(negedge clk);
        chk("mid reset in access", 48'(ren[2]), 48'd1);
        rst[2] = 1'b1;
        rd[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid reset ram_en", 48'({ren[2], rwe[2]}), 48'd0);
        chk("mid reset dones", 48'({idone[2], ddone[2]}), 48'd0);
        rst[2] = 1'b0;
        exp_d[2] = '0;
        exp_i[2] = '0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (idone[2] || ddone[2] || ren[2]) extra++;
        end
        chk("mid reset no later activity", 48'(extra), 48'd0);
        @(posedge clk);
        #1;
        txn("w3 read after reset", 2, 1, 0, 0, 15'o01234, 15'd0, 48'd0);
        txn("w3 write+fetch", 2, 0, 1, 1, 15'o00005, 15'o00005, 48'h0000_DEAD_BEEF);

        for (int k = 0; k < 45; k++) begin
            int          i    = int'($urandom_range(0, NI - 1));
            int          kind = int'($urandom_range(0, 5));
            logic [14:0] da, ia;
            logic [47:0] wd;
            da = $urandom_range(0, 1) ? 15'($urandom_range(0, 7)) : 15'($urandom);
            ia = $urandom_range(0, 1) ? 15'($urandom_range(0, 7)) : 15'($urandom);
            wd = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
            case (kind)
                0:       txn("rand read", i, 1, 0, 0, da, ia, wd);
                1:       txn("rand write", i, 0, 1, 0, da, ia, wd);
                2:       txn("rand fetch", i, 0, 0, 1, da, ia, wd);
                3:       txn("rand read+fetch", i, 1, 0, 1, da, ia, wd);
                4:       txn("rand write+fetch", i, 0, 1, 1, da, ia, wd);
                default: txn("rand read&write", i, 1, 1, 0, da, ia, wd);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
